// File: rtl/mult_div_unit.sv
// Multicycle signed multiply / restoring divide producing HI/LO.
// Optional MULTDIV_UNSIGNED_EN adds the is_unsigned port for multu/divu.
module mult_div_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  // state  | meaning
  // IDLE   | waiting for start (ignored during the done cycle)
  // RUN    | one multiply/divide bit per cycle, WIDTH cycles
  // FINISH | sign-correct and write hi/lo; two cycles on divide-by-zero
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             op_div_q, neg_q, neg_r;
  logic [WIDTH-1:0] acc_hi, acc_lo, mag_x;
  logic             uns;
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_sum, div_r, div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             start_ok, last_run, dz_hold;

`ifdef MULTDIV_UNSIGNED_EN
  assign uns = is_unsigned;
`else
  assign uns = 1'b0;
`endif

  assign start_ok = start && !done;
  assign last_run = (cnt_q == CNT_W'(WIDTH - 1));
  assign dz_hold  = div_zero && (cnt_q == '0);

  always_comb begin
    sa       = !uns && a[WIDTH-1];
    sb       = !uns && b[WIDTH-1];
    mag_a    = sa ? -a : a;
    mag_b    = sb ? -b : b;
    add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_x} : '0);
    div_r    = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = div_r - {1'b0, mag_x};
    div_ge   = (div_r >= {1'b0, mag_x});
    prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix  = neg_q ? -acc_lo : acc_lo;
    rem_fix  = neg_r ? -acc_hi : acc_hi;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = (op_div && b == '0) ? FINISH : RUN;
      RUN:     if (last_run) state_d = FINISH;
      FINISH:  if (!dz_hold) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mag_x    <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: if (start_ok) begin
          busy     <= 1'b1;
          div_zero <= op_div && (b == '0);
          cnt_q    <= '0;
          op_div_q <= op_div;
          neg_q    <= sa ^ sb;
          neg_r    <= sa;
          acc_hi   <= '0;
          // multiply shifts the multiplier out of acc_lo; divide shifts the dividend
          acc_lo   <= op_div ? mag_a : mag_b;
          mag_x    <= op_div ? mag_b : mag_a;
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (op_div_q) begin
            acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_r[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            {acc_hi, acc_lo} <= {add_sum, acc_lo[WIDTH-1:1]};
          end
        end
        FINISH: begin
          // divide-by-zero stays one extra cycle so done lands two edges after start
          if (dz_hold) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            done  <= 1'b1;
            busy  <= 1'b0;
            if (!div_zero) begin
              hi <= op_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
              lo <= op_div_q ? quo_fix : prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised multicycle signed multiply/divide unit for the multicycle CPU. It implements the mult and div instructions and writes the HI/LO result registers.
- The main FSM issues a one-cycle start pulse with the A/B register values. It waits for done, then reads hi/lo through the write-data selection path.
- Width is generic, so the same block serves the 32-bit core and narrower test configurations.

Parameters:
- WIDTH, 32, operand width and width of each of hi and lo.
- CNT_W, $clog2(WIDTH)+1, width of the internal iteration counter (derived; not to be overridden).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op_div  input  1  0 = multiply, 1 = divide; sampled with start.
- a  input  WIDTH  multiplicand / dividend; sampled with start.
- b  input  WIDTH  multiplier / divisor; sampled with start.
- is_unsigned  input  1  present only when MULTDIV_UNSIGNED_EN is defined.
- hi  output  WIDTH  product upper half / remainder.
- lo  output  WIDTH  product lower half / quotient.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  divide-by-zero flag.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset (also mid-operation): FSM goes to IDLE and the counter clears. hi=0, lo=0, busy=0, done=0, div_zero=0 after the edge. Any running operation is discarded.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - start=1 at edge E0 latches a, b and op_div, clears div_zero, and goes to RUN with counter=0.
  - busy=1 from E0.
  - If op_div=1 and b==0: go to FINISH directly (no RUN) and set div_zero=1.
- RUN:
  - Multiply: radix-2 shift-add on operand magnitudes, one bit per cycle.
  - Divide: restoring division on magnitudes, one quotient bit per cycle.
  - Exactly WIDTH cycles; leaves to FINISH when counter==WIDTH-1.
- FINISH (one cycle):
  - Normal result: sign correction is applied, then hi/lo are written at the exiting edge. done=1 and busy=0 for exactly one cycle, then return to IDLE.
  - Divide-by-zero: hi/lo are unchanged, done=1 for one cycle, div_zero=1.
- Latency:
  - Normal operation: hi/lo/done update at edge E0+WIDTH+1 (E0+33 for WIDTH=32).
  - Divide-by-zero: update at E0+2.
- hi/lo hold their value between operations and are written only in FINISH of a non-zero-divisor operation.
- Multiply: {hi,lo} = full 2*WIDTH-bit signed product.
- Divide:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Case a = most-negative, b = -1: lo = most-negative value (0x80000000), hi = 0. No flag.
- start while busy (RUN or FINISH) is ignored; no queueing.
- start in the same cycle as a done pulse is ignored. A new start is accepted only in IDLE, i.e. the cycle after done.
- div_zero holds until the next accepted start or reset.

Optional Feature:
- MULTDIV_UNSIGNED_EN defined:
  - is_unsigned port exists and is sampled with start.
  - When is_unsigned=1, operands are treated as unsigned (multu/divu) with no sign correction.
  - Divide-by-zero handling and latency are identical to the signed case.
- MULTDIV_UNSIGNED_EN undefined: no is_unsigned port; all operations are signed.

Test Plan:
- Signed multiply, WIDTH=32: a=7, b=-3 (0xFFFFFFFD) -> at E0+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; done high exactly 1 cycle; busy high from E0 to E0+33.
- Signed divide: a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1) at E0+33. Overflow case: a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- Divide by zero: load hi/lo with prior results, then a=5, b=0 -> at E0+2, done=1, div_zero=1, hi/lo unchanged. A following start with a=6, b=3 clears div_zero at its E0 and gives lo=2, hi=0.
- Start while busy: second start at E0+5 with different operands is ignored. First result appears at E0+33, and no second done occurs.
- Reset at E0+10 mid-multiply -> next edge: hi=lo=0, busy=0. No done pulse ever occurs for the aborted operation.
- MULTDIV_UNSIGNED_EN build, is_unsigned=1: 0xFFFFFFFF * 2 -> hi=0x00000001, lo=0xFFFFFFFE. Divide 0xFFFFFFFF / 0x10 -> lo=0x0FFFFFFF, hi=0xF.
